// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - shared widths and active-low 7-segment codes
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment (common anode).
package bcd_scan_display_pkg;

    localparam int BCD_W = 4;   // one BCD digit, shared with the counter chain
    localparam int SEG_W = 8;   // {dp,g,f,e,d,c,b,a}

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_scan_display_seg7.sv
// rtl/bcd_scan_display_seg7.sv - combinational BCD to active-low 7-segment decoder
// Ports:
//   code : 4-bit BCD code; 10..15 are not decimal digits and show a dash
//   seg  : {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
    import bcd_scan_display_pkg::*;
(
    input  logic [BCD_W-1:0] code,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - time-multiplexed BCD scan driver for a common-anode 7-segment display
// Ports:
//   clk, rst_n : clock; asynchronous active-low reset
//   bcd_in     : N_DIGITS packed BCD digits, digit 0 in bits [3:0]
//   dp_in      : decimal point request per digit, 1 = lit
//   lzb_en     : 1 = blank leading zeros
//   ssd_an     : digit enables, active-low, one digit at a time
//   ssd_seg    : {dp,g,f,e,d,c,b,a}, active-low
//   scan_tick  : one-cycle pulse at the end of every digit slot
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BCD_W*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]       dp_in,
    input  logic                      lzb_en,
    output logic [N_DIGITS-1:0]       ssd_an,
    output logic [SEG_W-1:0]          ssd_seg,
    output logic                      scan_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [DIV_W-1:0]          pre;
    logic [IDX_W-1:0]          idx;
    logic                      running;
    logic                      last_digit;
    logic [BCD_W*N_DIGITS-1:0] snap_bcd;
    logic [N_DIGITS-1:0]       snap_dp;
    logic                      snap_lzb;

    logic [BCD_W-1:0]          cur_code;
    logic                      cur_dp;
    logic                      cur_blank;
    logic [N_DIGITS-1:0]       an_next;
    logic [6:0]                dec_seg;

    assign scan_tick  = (pre == DIV_W'(SCAN_DIV - 1));
    assign last_digit = (idx == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (scan_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // idx starts on the last digit so the first tick wraps it to digit 0 and
    // simultaneously opens the first frame (snapshot capture).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= IDX_W'(N_DIGITS - 1);
            running  <= 1'b0;
            snap_bcd <= '0;
            snap_dp  <= '0;
            snap_lzb <= 1'b0;
        end else if (scan_tick) begin
            running <= 1'b1;
            idx     <= last_digit ? '0 : idx + 1'b1;
            if (last_digit) begin
                snap_bcd <= bcd_in;
                snap_dp  <= dp_in;
                snap_lzb <= lzb_en;
            end
        end
    end

    // Select the current digit from the frozen snapshot. A digit is blanked
    // only when it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        an_next   = '1;
        cur_blank = snap_lzb && (idx != '0);
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_code   = snap_bcd[BCD_W*k +: BCD_W];
                cur_dp     = snap_dp[k];
                an_next[k] = 1'b0;
            end
            if ((IDX_W'(k) >= idx) && (snap_bcd[BCD_W*k +: BCD_W] != '0)) begin
                cur_blank = 1'b0;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // Outputs are registered from the already-updated idx, so they trail idx by
    // one clock; they stay dark until the first slot has started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_an  <= '1;
            ssd_seg <= '1;
        end else if (running) begin
            ssd_an  <= an_next;
            ssd_seg <= {~cur_dp, (cur_blank ? SEG_BLANK : dec_seg)};
        end else begin
            ssd_an  <= '1;
            ssd_seg <= '1;
        end
    end

endmodule
